// File: rtl/axi_slave_mem.sv
// AXI3 memory slave: word-addressed RAM, independent write/read FSMs, one outstanding burst each way.
// Registered outputs; first R beat and B arrive one cycle after AR / last W; stalls hold every output.
module axi_slave_mem #(
  parameter int AXI_DWIDTH = 64,
  parameter int ID_WIDTH = 4,
  parameter int MEM_DEPTH = 256,
  localparam int AXI_STRBWIDTH = AXI_DWIDTH / 8
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [ID_WIDTH-1:0]      AWID,
  input  logic [31:0]              AWADDR,
  input  logic [3:0]               AWLEN,
  input  logic [2:0]               AWSIZE,
  input  logic [1:0]               AWBURST,
  input  logic [1:0]               AWLOCK,
  input  logic [3:0]               AWCACHE,
  input  logic [2:0]               AWPROT,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [ID_WIDTH-1:0]      WID,
  input  logic [AXI_DWIDTH-1:0]    WDATA,
  input  logic [AXI_STRBWIDTH-1:0] WSTRB,
  input  logic                     WLAST,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [ID_WIDTH-1:0]      BID,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [ID_WIDTH-1:0]      ARID,
  input  logic [31:0]              ARADDR,
  input  logic [3:0]               ARLEN,
  input  logic [2:0]               ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic [1:0]               ARLOCK,
  input  logic [3:0]               ARCACHE,
  input  logic [2:0]               ARPROT,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [ID_WIDTH-1:0]      RID,
  output logic [AXI_DWIDTH-1:0]    RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY
);
  localparam int OFFW = $clog2(AXI_STRBWIDTH);
  localparam int IDXW = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(OFFW);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [AXI_DWIDTH-1:0] mem [MEM_DEPTH];

  logic unused_ok;
  assign unused_ok = ^{AWLOCK, AWCACHE, AWPROT, ARLOCK, ARCACHE, ARPROT, WID};

  // BURST=11 falls into the default arm and is sequenced as INCR
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] incr;
    logic [31:0] bound;
    incr  = 32'd1 << size;
    bound = ({28'd0, len} + 32'd1) * incr;
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~(bound - 32'd1)) | ((addr + incr) & (bound - 32'd1));
      default: next_addr = addr + incr;
    endcase
  endfunction

  function automatic logic cfg_err(input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    cfg_err = (burst == 2'b11) || (size > MAX_SIZE) ||
              ((burst == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
  endfunction

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t    w_state, w_next;
  logic [31:0] w_addr;
  logic [3:0]  w_len, w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_err;
  logic        aw_hs, w_hs, b_hs, w_end, w_final;

  assign aw_hs   = AWVALID & AWREADY;
  assign w_hs    = WVALID & WREADY;
  assign b_hs    = BVALID & BREADY;
  assign w_final = (w_cnt == w_len);
  assign w_end   = w_hs & (WLAST | w_final);

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_end) w_next = W_RESP;
      W_RESP:  if (b_hs)  w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= RESP_OKAY;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_next;
      AWREADY <= (w_next == W_IDLE);
      WREADY  <= (w_next == W_DATA);
      BVALID  <= (w_next == W_RESP);
      if (aw_hs) begin
        BID     <= AWID;
        w_addr  <= AWADDR;
        w_len   <= AWLEN;
        w_size  <= AWSIZE;
        w_burst <= AWBURST;
        w_cnt   <= '0;
        w_err   <= cfg_err(AWLEN, AWSIZE, AWBURST);
      end
      if (w_hs) begin
        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
        w_cnt  <= w_cnt + 4'd1;
      end
      // WLAST must coincide exactly with beat LEN+1
      if (w_end)
        BRESP <= (w_err || (WLAST != w_final)) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_hs && !w_err) begin
      for (int b = 0; b < AXI_STRBWIDTH; b++)
        if (WSTRB[b]) mem[w_addr[OFFW +: IDXW]][b*8 +: 8] <= WDATA[b*8 +: 8];
    end
  end

  // ---------------- read channel ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  r_state_t    r_state, r_next;
  logic [31:0] r_addr, r_addr_nxt;
  logic [3:0]  r_len, r_cnt;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic        r_err, ar_err, ar_hs, r_hs;

  assign ar_hs      = ARVALID & ARREADY;
  assign r_hs       = RVALID & RREADY;
  assign ar_err     = cfg_err(ARLEN, ARSIZE, ARBURST);
  assign r_addr_nxt = next_addr(r_addr, r_len, r_size, r_burst);

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && RLAST) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
      RLAST   <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= r_next;
      ARREADY <= (r_next == R_IDLE);
      RVALID  <= (r_next == R_DATA);
      if (ar_hs) begin
        RID     <= ARID;
        r_addr  <= ARADDR;
        r_len   <= ARLEN;
        r_size  <= ARSIZE;
        r_burst <= ARBURST;
        r_cnt   <= '0;
        r_err   <= ar_err;
        RLAST   <= (ARLEN == 4'd0);
        RRESP   <= ar_err ? RESP_SLVERR : RESP_OKAY;
        RDATA   <= ar_err ? '0 : mem[ARADDR[OFFW +: IDXW]];
      end else if (r_hs && !RLAST) begin
        r_addr <= r_addr_nxt;
        r_cnt  <= r_cnt + 4'd1;
        RLAST  <= ((r_cnt + 4'd1) == r_len);
        RDATA  <= r_err ? '0 : mem[r_addr_nxt[OFFW +: IDXW]];
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomized scoreboard bench for axi_slave_mem against a byte-merging array model of the RAM.
module tb_axi_slave_mem;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int DEPTH = 256;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [IW-1:0] AWID, WID, BID, ARID, RID;
  logic [31:0]   AWADDR, ARADDR;
  logic [3:0]    AWLEN, AWCACHE, ARLEN, ARCACHE;
  logic [2:0]    AWSIZE, AWPROT, ARSIZE, ARPROT;
  logic [1:0]    AWBURST, AWLOCK, ARBURST, ARLOCK, BRESP, RRESP;
  logic          AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [7:0]    WSTRB;

  axi_slave_mem #(.AXI_DWIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

  logic [DW-1:0] ref_mem [DEPTH];
  b_exp_t b_q[$];
  r_exp_t r_q[$];
  logic [DW-1:0] wdat [16];
  logic [7:0]    wstb [16];

  function automatic bit is_err(input int len, input int size, input int burst);
    return burst == 3 || size > 3 || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // Word touched by beat i: byte address from burst rules, then modulo the RAM depth
  function automatic int beat_word(input longint unsigned addr, input int i, input int len,
                                   input int size, input int burst);
    longint unsigned incr, bnd, lower, a;
    incr = 64'd1 << size;
    bnd  = (len + 1) * incr;
    case (burst)
      0:       a = addr;
      2: begin
        lower = (addr / bnd) * bnd;
        a = lower + ((addr - lower) + i * incr) % bnd;
      end
      default: a = addr + i * incr;
    endcase
    return int'((a >> 3) % DEPTH);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d, input logic [7:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic fill_rand(input bit rand_strb);
    for (int i = 0; i < 16; i++) begin
      wdat[i] = {$urandom, $urandom};
      wstb[i] = rand_strb ? 8'($urandom) : 8'hFF;
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // ---------------- monitor ----------------
  int rbeats = 0;
  b_exp_t be;
  r_exp_t re;
  bit stall_seen = 0;
  logic [IW+DW+2:0] stall_val;

  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (BVALID && BREADY) begin
        if (b_q.size() == 0) timeout("b_unexpected_response");
        else begin
          be = b_q.pop_front();
          check("bid", BID, be.id);
          check("bresp", BRESP, be.resp);
        end
      end
      if (stall_seen) begin
        check("r_hold_valid", RVALID, 1);
        check("r_hold_payload", {RID, RDATA, RRESP, RLAST}, stall_val);
      end
      stall_seen = RVALID && !RREADY;
      stall_val  = {RID, RDATA, RRESP, RLAST};
      if (RVALID && RREADY) begin
        rbeats++;
        if (r_q.size() == 0) timeout("r_unexpected_beat");
        else begin
          re = r_q.pop_front();
          check("rid", RID, re.id);
          check("rdata", RDATA, re.data);
          check("rresp", RRESP, re.resp);
          check("rlast", RLAST, re.last);
        end
      end
    end else stall_seen = 0;
  end

  // ---------------- drivers ----------------
  task automatic do_write(input logic [IW-1:0] id, input logic [31:0] addr, input int len, input int size,
                          input int burst, input int last_at, input int bdelay, input bit gaps);
    bit err, ok;
    int nbeats, n;
    logic [1:0] resp;
    err    = is_err(len, size, burst);
    nbeats = (last_at >= 0 && last_at < len) ? last_at + 1 : len + 1;
    resp   = (err || last_at != len) ? 2'b10 : 2'b00;
    b_q.push_back(b_exp_t'{id: id, resp: resp});
    AWID = id; AWADDR = addr; AWLEN = 4'(len); AWSIZE = 3'(size); AWBURST = 2'(burst); AWVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); ok = AWREADY; tick(); n++; end while (!ok && n < 50);
    AWVALID = 1'b0;
    if (!ok) timeout("aw_handshake");
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) tick();
      WID = id; WDATA = wdat[i]; WSTRB = wstb[i]; WLAST = (i == last_at); WVALID = 1'b1;
      if (!err) ref_mem[beat_word(addr, i, len, size, burst)] =
                  merge(ref_mem[beat_word(addr, i, len, size, burst)], wdat[i], wstb[i]);
      n = 0;
      do begin @(negedge ACLK); ok = WREADY; tick(); n++; end while (!ok && n < 50);
      WVALID = 1'b0; WLAST = 1'b0;
      if (!ok) timeout("w_handshake");
    end
    n = 0;
    while (!BVALID && n < 50) begin tick(); n++; end
    check("b_latency", n, 0);
    repeat (bdelay) begin tick(); check("bvalid_hold", BVALID, 1); end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
  endtask

  // rmode 0: RREADY high, 1: toggling, 2: random
  task automatic do_read(input logic [IW-1:0] id, input logic [31:0] addr, input int len, input int size,
                         input int burst, input int rmode);
    bit err, ok, done, saw_rst;
    int n;
    err = is_err(len, size, burst);
    for (int i = 0; i <= len; i++)
      r_q.push_back(r_exp_t'{id: id, data: err ? '0 : ref_mem[beat_word(addr, i, len, size, burst)],
                             resp: err ? 2'b10 : 2'b00, last: (i == len)});
    ARID = id; ARADDR = addr; ARLEN = 4'(len); ARSIZE = 3'(size); ARBURST = 2'(burst); ARVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); ok = ARREADY; tick(); n++; end while (!ok && n < 50);
    ARVALID = 1'b0;
    if (!ok) timeout("ar_handshake");
    n = 0; done = 0; saw_rst = 0;
    while (!done && n < 200) begin
      RREADY = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'(n % 2) : 1'($urandom_range(0, 1));
      @(negedge ACLK);
      done = RVALID && RREADY && RLAST;
      tick();
      n++;
      if (!ARESETN) begin saw_rst = 1; break; end
    end
    RREADY = 1'b0;
    if (!done && !saw_rst) timeout("r_burst_complete");
  endtask

  // ---------------- sequence ----------------
  initial begin
    int base, n, len, size, burst, last_at;
    logic [31:0] addr;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWLOCK = '0; AWCACHE = '0; AWPROT = '0;
    AWVALID = 0; WID = '0; WDATA = '0; WSTRB = '0; WLAST = 0; WVALID = 0; BREADY = 0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARLOCK = '0; ARCACHE = '0; ARPROT = '0;
    ARVALID = 0; RREADY = 0;
    repeat (3) tick();
    check("rst_awready", AWREADY, 0); check("rst_wready", WREADY, 0);
    check("rst_bvalid", BVALID, 0);   check("rst_bid", BID, 0);
    check("rst_bresp", BRESP, 0);     check("rst_arready", ARREADY, 0);
    check("rst_rvalid", RVALID, 0);   check("rst_rid", RID, 0);
    check("rst_rdata", RDATA, 0);     check("rst_rresp", RRESP, 0);
    check("rst_rlast", RLAST, 0);
    ARESETN = 1'b1;
    tick();
    check("post_rst_awready", AWREADY, 1);
    check("post_rst_arready", ARREADY, 1);

    for (int k = 0; k < 16; k++) begin
      fill_rand(0);
      do_write(4'(k), 32'(k * 128), 15, 3, 1, 15, 0, 0);
    end

    wdat[0] = 64'haaaa5555aaaa5555; wstb[0] = 8'hFE;
    do_write(4'h5, 32'h10, 0, 3, 1, 0, 0, 0);
    do_read(4'h6, 32'h10, 0, 3, 1, 0);

    fill_rand(0);
    do_write(4'h1, 32'h0, 3, 3, 1, 3, 1, 1);
    do_read(4'h2, 32'h0, 3, 3, 1, 1);
    do_read(4'h3, 32'h18, 3, 3, 2, 0);
    do_read(4'h4, 32'h20, 2, 3, 0, 2);

    do_read(4'h7, 32'h40, 5, 3, 3, 2);
    fill_rand(0);
    do_write(4'h8, 32'h48, 1, 4, 1, 1, 0, 0);
    do_read(4'h9, 32'h48, 1, 3, 1, 0);
    do_write(4'hA, 32'h80, 3, 3, 1, 1, 0, 0);
    do_write(4'hB, 32'h100, 1, 3, 1, -1, 0, 0);
    do_read(4'hC, 32'h80, 3, 3, 1, 0);
    do_read(4'hD, 32'h0, 2, 3, 2, 0);

    fill_rand(1);
    fork
      do_write(4'hE, 32'h200, 1, 3, 1, 1, 0, 0);
      do_read(4'hF, 32'h300, 1, 3, 1, 0);
    join

    base = rbeats;
    fork
      do_read(4'h3, 32'h0, 7, 3, 1, 0);
      begin
        n = 0;
        while (rbeats == base && n < 50) begin tick(); n++; end
        if (rbeats == base) timeout("reset_trigger");
        #1 ARESETN = 1'b0;
        @(negedge ACLK);
        check("mid_rst_rvalid", RVALID, 0);
        check("mid_rst_arready", ARREADY, 0);
        r_q.delete();
        repeat (2) tick();
        ARESETN = 1'b1;
      end
    join
    tick();
    check("rel_awready", AWREADY, 1);
    check("rel_arready", ARREADY, 1);
    do_read(4'h2, 32'h10, 1, 3, 1, 0);

    for (int t = 0; t < 30; t++) begin
      addr    = $urandom;
      len     = $urandom_range(0, 15);
      size    = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 4) : 3;
      burst   = $urandom_range(0, 3);
      last_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : len;
      fill_rand(1);
      do_write(4'(t), addr, len, size, burst, last_at, $urandom_range(0, 2), 1);
      len     = $urandom_range(0, 15);
      burst   = ($urandom_range(0, 3) == 0) ? 2 : $urandom_range(0, 1);
      if (burst == 2) len = (1 << $urandom_range(1, 4)) - 1;
      do_read(4'(t + 1), addr, len, 3, burst, 2);
    end

    repeat (4) tick();
    check("b_queue_drained", b_q.size(), 0);
    check("r_queue_drained", r_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

Synthesizable AXI3 memory slave that terminates one CoreAXI slave port in the CoreAXI test environment. It sits directly downstream of the AXI master model and the interconnect. It accepts write and read bursts into an internal word-addressed RAM and returns well-formed B and R responses with error signalling. Write and read channels run independently, with one outstanding transaction per direction.

## Interface
Parameters:
- AXI_DWIDTH, 64, data width (64/128/256); AXI_STRBWIDTH = AXI_DWIDTH/8
- ID_WIDTH, 4, width of AWID/WID/BID/ARID/RID
- MEM_DEPTH, 256, RAM depth in AXI_DWIDTH words (power of 2)

Ports (clock and reset first; single clock ACLK; ARESETN asynchronous, active-low):
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWLOCK/AWCACHE/AWPROT  in  ID_WIDTH/32/4/3/2/2/4/3  write address; LOCK/CACHE/PROT ignored
- AWVALID  in  1; AWREADY  out  1
- WID/WDATA/WSTRB/WLAST/WVALID  in  ID_WIDTH/AXI_DWIDTH/AXI_STRBWIDTH/1/1  write data; WREADY  out  1
- BID/BRESP/BVALID  out  ID_WIDTH/2/1  write response; BREADY  in  1
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT  in  as AW; ARVALID  in  1; ARREADY  out  1
- RID/RDATA/RRESP/RLAST/RVALID  out  ID_WIDTH/AXI_DWIDTH/2/1/1  read data; RREADY  in  1

## Operation
- Word index = addr[log2(AXI_STRBWIDTH) +: log2(MEM_DEPTH)]; higher address bits are ignored, so the index wraps modulo MEM_DEPTH.
- Beat increment = 2^SIZE bytes.
  - FIXED (00): address constant.
  - INCR (01): addr += incr.
  - WRAP (10): boundary B = (LEN+1)*incr; addr = (addr & ~(B-1)) | ((addr+incr) & (B-1)).
- Error (SLVERR = 2'b10) when any of:
  - BURST = 11;
  - SIZE > log2(AXI_STRBWIDTH);
  - WRAP with LEN not in {1,3,7,15}.
  - An errored burst is handshaked for its full length. Writes are suppressed; BURST=11 is otherwise sequenced as INCR.
- Write FSM:
  - W_IDLE: AWREADY=1. On AWVALID, capture ID/addr/len/size/burst/error and go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID beat writes the RAM bytes enabled by WSTRB (no write when errored), advances the address and increments the beat counter.
  - The burst ends on WLAST or on beat LEN+1, whichever comes first; go to W_RESP. WLAST early, or missing on beat LEN+1, forces BRESP=SLVERR.
  - W_RESP: BVALID=1, BID=captured AWID, BRESP=OKAY/SLVERR. On BREADY, return to W_IDLE.
- Read FSM:
  - R_IDLE: ARREADY=1. On ARVALID, capture, load RDATA from the RAM at ARADDR, and go to R_DATA.
  - R_DATA: RVALID=1, RID=captured ARID, RLAST=(beat==LEN). RRESP=SLVERR with RDATA=0 when errored.
  - On RREADY: if last, go to R_IDLE; otherwise advance the address and load the next word.
- WID is not checked.
- Same-cycle read load and write to the same word: the read returns the pre-write value.

## Timing
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0, ARREADY=0, RVALID=0, RID=0, RDATA=0, RRESP=0, RLAST=0.
- First cycle after deassertion: AWREADY=1, ARREADY=1. RAM contents are not reset.
- All outputs are registered. A handshake completes on a rising edge with VALID&READY.
- AW handshake at edge N: AWREADY=0 and WREADY=1 after N. W beats are accepted from edge N+1, and W data presented before that is held by the master.
- Last W beat at edge M: BVALID=1 after M; BVALID holds until BREADY.
- AR handshake at edge N: RVALID and first RDATA valid after N. With RREADY held high, one beat per cycle; an LEN=15 read completes in 16 cycles.
- VALID outputs never drop without a handshake. Read data, ID and last/response remain stable while stalled.
- ARESETN assertion mid-burst: both FSMs return to idle immediately, all outputs go to reset values, and partial write beats already written stay in RAM.

## Test plan
- Single write: AWADDR=0x10, LEN=0, SIZE=3, INCR, WDATA=64'haaaa5555aaaa5555, WSTRB=8'hFE -> BRESP=00, BID=AWID. Then read 0x10 -> RDATA=64'haaaa5555aaaa55xx with the old byte 0 retained, RLAST=1.
- INCR write at 0x00, LEN=3, distinct data per beat, BREADY delayed 1 cycle -> BVALID held. Read back LEN=3 with RREADY toggling -> 4 beats in order, RLAST only on beat 4.
- WRAP read at 0x18, LEN=3, SIZE=3 -> words 3,0,1,2. FIXED read LEN=2 -> same word returned 3 times.
- Error cases:
  - ARBURST=11 -> 1+LEN beats with RRESP=10, RDATA=0.
  - AWSIZE=4 at 64-bit width -> BRESP=10 and RAM unchanged.
  - WLAST on beat 1 of a LEN=3 burst -> BRESP=10.
- Concurrent AW and AR at the same cycle to different words -> both complete independently with correct IDs.
- ARESETN pulsed during beat 2 of a LEN=7 read -> RVALID=0 next cycle; AWREADY/ARREADY=1 after release; a new read succeeds.
